// File: rtl/board_renderer_pipelined.sv
// Pipelined VGA renderer for the connect-four board: synchronous board read,
// 2-cycle colour/sync latency, falling-piece animation and winner blink.
module board_renderer_pipelined #(
   parameter int unsigned ROWS          = 8,
   parameter int unsigned COLS          = 8,
   parameter int unsigned CELL_LOG2     = 5,
   parameter int unsigned BOARD_X       = 192,
   parameter int unsigned BOARD_Y       = 112,
   parameter int unsigned CURSOR_OFFSET = 16,
   parameter int unsigned RADIUS        = 14,
   parameter int unsigned FALL_FRAMES   = 4,
   parameter int unsigned BLINK_FRAMES  = 16,
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk_25MHz,
   input  logic          rst,
   input  logic [9:0]    h_count,
   input  logic [9:0]    v_count,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          frame_start,
   output logic [RW-1:0] board_rd_row,
   output logic [CW-1:0] board_rd_col,
   input  logic [1:0]    board_rd_data,
   input  logic [CW-1:0] current_col,
   input  logic [1:0]    current_player,
   input  logic [1:0]    winner,
   input  logic          drop_start,
   input  logic [CW-1:0] drop_col,
   input  logic [RW-1:0] drop_row,
   input  logic [1:0]    drop_player,
   output logic          drop_busy,
   output logic          drop_done,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic [1:0]    vga_r,
   output logic [1:0]    vga_g,
   output logic [1:0]    vga_b
);

   localparam int unsigned CELL    = 1 << CELL_LOG2;
   localparam int unsigned HALF    = CELL / 2;
   localparam int unsigned SW      = 2 * CELL_LOG2 + 1;
   localparam int unsigned R_SQ    = RADIUS * RADIUS;
   localparam int unsigned X_END   = BOARD_X + COLS * CELL;
   localparam int unsigned Y_END   = BOARD_Y + ROWS * CELL;
   localparam int unsigned BAND_Y1 = BOARD_Y - CURSOR_OFFSET;
   localparam int unsigned BAND_Y0 = BAND_Y1 - CELL;
   localparam int unsigned FW      = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;
   localparam int unsigned BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [5:0] RGB_BLACK  = 6'b00_00_00;
   localparam logic [5:0] RGB_BLUE   = 6'b00_00_11;
   localparam logic [5:0] RGB_EMPTY  = 6'b01_11_01;
   localparam logic [5:0] RGB_YELLOW = 6'b11_11_00;
   localparam logic [5:0] RGB_RED    = 6'b11_00_00;

   typedef enum logic {S_IDLE = 1'b0, S_FALL = 1'b1} state_t;

   // Distance from the cell centre, taken as magnitudes so the sum cannot wrap.
   function automatic logic f_in_circle(input logic [CELL_LOG2-1:0] px,
                                        input logic [CELL_LOG2-1:0] py);
      logic [SW-1:0] ax;
      logic [SW-1:0] ay;
      ax = (SW'(px) >= SW'(HALF)) ? SW'(px) - SW'(HALF) : SW'(HALF) - SW'(px);
      ay = (SW'(py) >= SW'(HALF)) ? SW'(py) - SW'(HALF) : SW'(HALF) - SW'(py);
      return (ax * ax + ay * ay) <= SW'(R_SQ);
   endfunction

   function automatic logic [5:0] f_player_rgb(input logic [1:0] p);
      case (p)
         2'b01:   return RGB_YELLOW;
         2'b10:   return RGB_RED;
         default: return RGB_EMPTY;
      endcase
   endfunction

   // Stage 0: pixel geometry
   logic [31:0]          w_h32;
   logic [31:0]          w_v32;
   logic [9:0]           w_ox;
   logic [9:0]           w_oy;
   logic [CELL_LOG2-1:0] w_by;
   logic                 w_in_x;
   logic                 w_in_board;
   logic                 w_in_band;
   logic                 w_in_circle;
   logic                 w_active;
   logic [CW-1:0]        w_col;
   logic [RW-1:0]        w_row;

   assign w_h32       = 32'(h_count);
   assign w_v32       = 32'(v_count);
   assign w_ox        = 10'(w_h32 - BOARD_X);
   assign w_oy        = 10'(w_v32 - BOARD_Y);
   assign w_by        = CELL_LOG2'(w_v32 - BAND_Y0);
   assign w_in_x      = (w_h32 >= BOARD_X) && (w_h32 < X_END);
   assign w_in_board  = w_in_x && (w_v32 >= BOARD_Y) && (w_v32 < Y_END);
   assign w_in_band   = w_in_x && (w_v32 >= BAND_Y0) && (w_v32 < BAND_Y1);
   assign w_col       = CW'(w_ox >> CELL_LOG2);
   assign w_row       = RW'(ROWS - 1) - RW'(w_oy >> CELL_LOG2);
   assign w_active    = (h_count < 10'd640) && (v_count < 10'd480);
   // The cursor band is not cell-aligned with the board, so it gets its own vertical origin.
   assign w_in_circle = w_in_band ? f_in_circle(w_ox[CELL_LOG2-1:0], w_by)
                                  : f_in_circle(w_ox[CELL_LOG2-1:0], w_oy[CELL_LOG2-1:0]);

   assign board_rd_col = w_col;
   assign board_rd_row = w_row;

   // Stage 1 register, aligned with board_rd_data
   logic          r1_in_board;
   logic          r1_in_band;
   logic          r1_in_circle;
   logic          r1_active;
   logic [CW-1:0] r1_col;
   logic [RW-1:0] r1_row;
   logic          r1_hs;
   logic          r1_vs;

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r1_in_board  <= 1'b0;
         r1_in_band   <= 1'b0;
         r1_in_circle <= 1'b0;
         r1_active    <= 1'b0;
         r1_col       <= '0;
         r1_row       <= '0;
         r1_hs        <= 1'b1;
         r1_vs        <= 1'b1;
      end else begin
         r1_in_board  <= w_in_board;
         r1_in_band   <= w_in_band;
         r1_in_circle <= w_in_circle;
         r1_active    <= w_active;
         r1_col       <= w_col;
         r1_row       <= w_row;
         r1_hs        <= hsync_in;
         r1_vs        <= vsync_in;
      end
   end

   // Drop animation FSM
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_drop_col;
   logic [CW-1:0] w_drop_col_nxt;
   logic [RW-1:0] r_drop_row;
   logic [RW-1:0] w_drop_row_nxt;
   logic [1:0]    r_drop_player;
   logic [1:0]    w_drop_player_nxt;
   logic [RW-1:0] r_anim_row;
   logic [RW-1:0] w_anim_row_nxt;
   logic [FW-1:0] r_frame_cnt;
   logic [FW-1:0] w_frame_cnt_nxt;
   logic          r_drop_done;
   logic          w_drop_done_nxt;

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_drop_col    <= '0;
         r_drop_row    <= '0;
         r_drop_player <= '0;
         r_anim_row    <= '0;
         r_frame_cnt   <= '0;
         r_drop_done   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_drop_col    <= w_drop_col_nxt;
         r_drop_row    <= w_drop_row_nxt;
         r_drop_player <= w_drop_player_nxt;
         r_anim_row    <= w_anim_row_nxt;
         r_frame_cnt   <= w_frame_cnt_nxt;
         r_drop_done   <= w_drop_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_drop_col_nxt    = r_drop_col;
      w_drop_row_nxt    = r_drop_row;
      w_drop_player_nxt = r_drop_player;
      w_anim_row_nxt    = r_anim_row;
      w_frame_cnt_nxt   = r_frame_cnt;
      w_drop_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (drop_start && (32'(drop_row) <= ROWS - 1) && (32'(drop_col) <= COLS - 1)) begin
               w_state_nxt       = S_FALL;
               w_drop_col_nxt    = drop_col;
               w_drop_row_nxt    = drop_row;
               w_drop_player_nxt = drop_player;
               w_anim_row_nxt    = RW'(ROWS - 1);
               w_frame_cnt_nxt   = '0;
            end
         end
         S_FALL: begin
            if (frame_start) begin
               if (r_frame_cnt == FW'(FALL_FRAMES - 1)) begin
                  w_frame_cnt_nxt = '0;
                  if (r_anim_row > r_drop_row) begin
                     w_anim_row_nxt = r_anim_row - RW'(1);
                  end else begin
                     w_drop_done_nxt = 1'b1;
                     w_state_nxt     = S_IDLE;
                  end
               end else begin
                  w_frame_cnt_nxt = r_frame_cnt + FW'(1);
               end
            end
         end
      endcase
   end

   assign drop_busy = (r_state == S_FALL);
   assign drop_done = r_drop_done;

   // Winner blink: phase toggles every BLINK_FRAMES frames while a player has won
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_on;
   logic          w_has_winner;

   assign w_has_winner = (winner == 2'b01) || (winner == 2'b10);

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (!w_has_winner) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (frame_start) begin
         if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   // Stage 2 colour selection
   logic [5:0] w_rgb;

   always_comb begin
      w_rgb = RGB_EMPTY;
      if (!r1_active) begin
         w_rgb = RGB_BLACK;
      end else if (r1_in_board && !r1_in_circle) begin
         w_rgb = RGB_BLUE;
      end else if (r1_in_board) begin
         if (drop_busy && (r1_col == r_drop_col) && (r1_row == r_anim_row)) begin
            w_rgb = f_player_rgb(r_drop_player);
         end else if (w_has_winner && (board_rd_data == winner) && !r_blink_on) begin
            w_rgb = RGB_EMPTY;
         end else begin
            w_rgb = f_player_rgb(board_rd_data);
         end
      end else if (r1_in_band && (r1_col == current_col) && r1_in_circle &&
                   (winner == 2'b00) && !drop_busy) begin
         w_rgb = f_player_rgb(current_player);
      end
   end

   logic [5:0] r2_rgb;
   logic       r2_hs;
   logic       r2_vs;

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r2_rgb <= RGB_BLACK;
         r2_hs  <= 1'b1;
         r2_vs  <= 1'b1;
      end else begin
         r2_rgb <= w_rgb;
         r2_hs  <= r1_hs;
         r2_vs  <= r1_vs;
      end
   end

   assign vga_r     = r2_rgb[5:4];
   assign vga_g     = r2_rgb[3:2];
   assign vga_b     = r2_rgb[1:0];
   assign vga_hsync = r2_hs;
   assign vga_vsync = r2_vs;

endmodule

// File: tb/tb_board_renderer_pipelined.sv
// Directed bench for board_renderer_pipelined: pixel vector table, sync
// sweep, winner blink, drop animation and reset during a drop.
module tb_board_renderer_pipelined;

   localparam logic [5:0] BLACK  = 6'b00_00_00;
   localparam logic [5:0] BLUE   = 6'b00_00_11;
   localparam logic [5:0] EMPTY  = 6'b01_11_01;
   localparam logic [5:0] YEL    = 6'b11_11_00;
   localparam logic [5:0] RED    = 6'b11_00_00;

   logic       clk_25MHz = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] h_count = '0;
   logic [9:0] v_count = '0;
   logic       hsync_in = 1'b1;
   logic       vsync_in = 1'b1;
   logic       frame_start = 1'b0;
   logic [2:0] board_rd_row;
   logic [2:0] board_rd_col;
   logic [1:0] board_rd_data;
   logic [2:0] current_col = '0;
   logic [1:0] current_player = 2'b01;
   logic [1:0] winner = 2'b00;
   logic       drop_start = 1'b0;
   logic [2:0] drop_col = '0;
   logic [2:0] drop_row = '0;
   logic [1:0] drop_player = '0;
   logic       drop_busy;
   logic       drop_done;
   logic       vga_hsync;
   logic       vga_vsync;
   logic [1:0] vga_r;
   logic [1:0] vga_g;
   logic [1:0] vga_b;

   int n_checks = 0;
   int n_fail = 0;
   int n_done = 0;

   logic [1:0] tb_board [0:7][0:7];

   board_renderer_pipelined dut (
      .clk_25MHz(clk_25MHz), .rst(rst), .h_count(h_count), .v_count(v_count),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
      .board_rd_row(board_rd_row), .board_rd_col(board_rd_col), .board_rd_data(board_rd_data),
      .current_col(current_col), .current_player(current_player), .winner(winner),
      .drop_start(drop_start), .drop_col(drop_col), .drop_row(drop_row),
      .drop_player(drop_player), .drop_busy(drop_busy), .drop_done(drop_done),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   // Board store with a synchronous read port
   always @(posedge clk_25MHz) board_rd_data <= tb_board[board_rd_row][board_rd_col];

   always @(posedge clk_25MHz) if (drop_done === 1'b1) n_done <= n_done + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v, output logic [5:0] rgb);
      h_count = h;
      v_count = v;
      repeat (2) @(posedge clk_25MHz);
      #1;
      rgb = {vga_r, vga_g, vga_b};
   endtask

   task automatic frame_pulse(input int n);
      for (int k = 0; k < n; k++) begin
         frame_start = 1'b1;
         @(posedge clk_25MHz);
         #1;
         frame_start = 1'b0;
      end
   endtask

   task automatic drop_req(input logic [2:0] c, input logic [2:0] r, input logic [1:0] p);
      drop_col    = c;
      drop_row    = r;
      drop_player = p;
      drop_start  = 1'b1;
      @(posedge clk_25MHz);
      #1;
      drop_start = 1'b0;
   endtask

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic [1:0] win;
      logic [2:0] ccol;
      logic [1:0] cpl;
      logic       chk_addr;
      logic [2:0] erow;
      logic [2:0] ecol;
      logic [5:0] ergb;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];
   logic [1:0] sync_hist [0:641];
   logic [5:0] rgb;
   logic [5:0] exp_rgb;
   int done_snap;

   initial begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            tb_board[r][c] = 2'b00;
      tb_board[7][0] = 2'b01;
      tb_board[6][1] = 2'b10;

      vecs[0]  = '{10'd208, 10'd128, 2'b00, 3'd3, 2'b10, 1'b1, 3'd7, 3'd0, YEL};
      vecs[1]  = '{10'd192, 10'd112, 2'b00, 3'd3, 2'b10, 1'b1, 3'd7, 3'd0, BLUE};
      vecs[2]  = '{10'd304, 10'd80,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, RED};
      vecs[3]  = '{10'd304, 10'd80,  2'b01, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[4]  = '{10'd240, 10'd160, 2'b00, 3'd3, 2'b10, 1'b1, 3'd6, 3'd1, RED};
      vecs[5]  = '{10'd222, 10'd128, 2'b00, 3'd3, 2'b10, 1'b1, 3'd7, 3'd0, YEL};
      vecs[6]  = '{10'd223, 10'd128, 2'b00, 3'd3, 2'b10, 1'b1, 3'd7, 3'd0, BLUE};
      vecs[7]  = '{10'd208, 10'd142, 2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, YEL};
      vecs[8]  = '{10'd272, 10'd128, 2'b00, 3'd3, 2'b10, 1'b1, 3'd7, 3'd2, EMPTY};
      vecs[9]  = '{10'd448, 10'd128, 2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[10] = '{10'd640, 10'd128, 2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, BLACK};
      vecs[11] = '{10'd100, 10'd480, 2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, BLACK};
      vecs[12] = '{10'd208, 10'd80,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[13] = '{10'd289, 10'd80,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[14] = '{10'd290, 10'd80,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, RED};
      vecs[15] = '{10'd304, 10'd80,  2'b11, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[16] = '{10'd447, 10'd367, 2'b00, 3'd3, 2'b10, 1'b1, 3'd0, 3'd7, BLUE};
      vecs[17] = '{10'd191, 10'd128, 2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[18] = '{10'd304, 10'd63,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};
      vecs[19] = '{10'd304, 10'd66,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, RED};
      vecs[20] = '{10'd304, 10'd94,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, RED};
      vecs[21] = '{10'd304, 10'd95,  2'b00, 3'd3, 2'b10, 1'b0, 3'd0, 3'd0, EMPTY};

      // Reset state with an active in-board pixel and low syncs on the inputs
      h_count  = 10'd208;
      v_count  = 10'd128;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      repeat (3) @(posedge clk_25MHz);
      #1;
      chk("rst_hsync", 32'(vga_hsync), 32'd1);
      chk("rst_vsync", 32'(vga_vsync), 32'd1);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(BLACK));
      chk("rst_busy", 32'(drop_busy), 32'd0);
      chk("rst_done", 32'(drop_done), 32'd0);
      rst = 1'b0;
      @(posedge clk_25MHz);
      #1;

      // Line 0 sweep with random syncs, checked two cycles later
      for (int i = 0; i < 644; i++) begin
         if (i >= 2) begin
            exp_rgb = (i - 2 < 640) ? EMPTY : BLACK;
            chk($sformatf("sweep_rgb_h%0d", i - 2), 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
            chk($sformatf("sweep_hs_h%0d", i - 2), 32'(vga_hsync), 32'(sync_hist[i-2][1]));
            chk($sformatf("sweep_vs_h%0d", i - 2), 32'(vga_vsync), 32'(sync_hist[i-2][0]));
         end
         if (i < 642) begin
            h_count  = 10'(i);
            v_count  = 10'd0;
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            sync_hist[i] = {hsync_in, vsync_in};
         end
         @(posedge clk_25MHz);
         #1;
      end
      hsync_in = 1'b1;
      vsync_in = 1'b1;

      // Pixel vector table
      for (int i = 0; i < NV; i++) begin
         winner         = vecs[i].win;
         current_col    = vecs[i].ccol;
         current_player = vecs[i].cpl;
         h_count        = vecs[i].h;
         v_count        = vecs[i].v;
         #1;
         if (vecs[i].chk_addr) begin
            chk($sformatf("vec%0d_rd_row", i), 32'(board_rd_row), 32'(vecs[i].erow));
            chk($sformatf("vec%0d_rd_col", i), 32'(board_rd_col), 32'(vecs[i].ecol));
         end
         pix(vecs[i].h, vecs[i].v, rgb);
         chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].ergb));
      end
      winner = 2'b00;

      // Winner blink on the P2 piece at (col 1, row 6)
      winner = 2'b10;
      pix(10'd240, 10'd160, rgb); chk("blink_f0", 32'(rgb), 32'(RED));
      frame_pulse(15);
      pix(10'd240, 10'd160, rgb); chk("blink_f15", 32'(rgb), 32'(RED));
      frame_pulse(1);
      pix(10'd240, 10'd160, rgb); chk("blink_f16", 32'(rgb), 32'(EMPTY));
      pix(10'd208, 10'd128, rgb); chk("blink_loser_piece", 32'(rgb), 32'(YEL));
      frame_pulse(15);
      pix(10'd240, 10'd160, rgb); chk("blink_f31", 32'(rgb), 32'(EMPTY));
      frame_pulse(1);
      pix(10'd240, 10'd160, rgb); chk("blink_f32", 32'(rgb), 32'(RED));
      frame_pulse(16);
      pix(10'd240, 10'd160, rgb); chk("blink_f48", 32'(rgb), 32'(EMPTY));
      winner = 2'b00;
      pix(10'd240, 10'd160, rgb); chk("blink_clear", 32'(rgb), 32'(RED));
      winner = 2'b11;
      frame_pulse(16);
      pix(10'd240, 10'd160, rgb); chk("draw_f16", 32'(rgb), 32'(RED));
      frame_pulse(16);
      pix(10'd240, 10'd160, rgb); chk("draw_f32", 32'(rgb), 32'(RED));
      winner = 2'b00;

      // Drop animation: col 2 lands on row 5
      done_snap = n_done;
      drop_req(3'd2, 3'd5, 2'b01);
      chk("drop_busy_start", 32'(drop_busy), 32'd1);
      pix(10'd272, 10'd128, rgb); chk("ovl_row7", 32'(rgb), 32'(YEL));
      frame_pulse(3);
      pix(10'd272, 10'd128, rgb); chk("ovl_row7_f3", 32'(rgb), 32'(YEL));
      frame_pulse(1);
      pix(10'd272, 10'd128, rgb); chk("ovl_left_row7", 32'(rgb), 32'(EMPTY));
      pix(10'd272, 10'd160, rgb); chk("ovl_row6", 32'(rgb), 32'(YEL));
      drop_req(3'd5, 3'd0, 2'b10);
      pix(10'd272, 10'd160, rgb); chk("ovl_ignore_2nd", 32'(rgb), 32'(YEL));
      chk("busy_after_2nd", 32'(drop_busy), 32'd1);
      frame_pulse(4);
      pix(10'd272, 10'd192, rgb); chk("ovl_row5", 32'(rgb), 32'(YEL));
      frame_pulse(3);
      chk("busy_f11", 32'(drop_busy), 32'd1);
      chk("no_done_f11", 32'(n_done - done_snap), 32'd0);
      frame_pulse(1);
      chk("done_f12", 32'(drop_done), 32'd1);
      chk("busy_low_f12", 32'(drop_busy), 32'd0);
      @(posedge clk_25MHz);
      #1;
      chk("done_one_cycle", 32'(drop_done), 32'd0);
      chk("done_count", 32'(n_done - done_snap), 32'd1);
      pix(10'd272, 10'd192, rgb); chk("ovl_gone", 32'(rgb), 32'(EMPTY));
      chk("idle_after_land", 32'(drop_busy), 32'd0);

      // Reset in the middle of a drop
      drop_req(3'd2, 3'd0, 2'b01);
      frame_pulse(5);
      chk("busy_before_rst", 32'(drop_busy), 32'd1);
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      h_count  = 10'd208;
      v_count  = 10'd128;
      rst = 1'b1;
      #1;
      chk("rst_async_busy", 32'(drop_busy), 32'd0);
      repeat (2) @(posedge clk_25MHz);
      #1;
      chk("rst_mid_hsync", 32'(vga_hsync), 32'd1);
      chk("rst_mid_vsync", 32'(vga_vsync), 32'd1);
      chk("rst_mid_rgb", 32'({vga_r, vga_g, vga_b}), 32'(BLACK));
      chk("rst_mid_done", 32'(drop_done), 32'd0);
      rst = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      done_snap = n_done;
      frame_pulse(20);
      chk("no_done_after_rst", 32'(n_done - done_snap), 32'd0);
      chk("idle_after_rst", 32'(drop_busy), 32'd0);
      drop_req(3'd2, 3'd7, 2'b10);
      pix(10'd272, 10'd128, rgb); chk("ovl_red_row7", 32'(rgb), 32'(RED));
      frame_pulse(3);
      chk("busy_top_f3", 32'(drop_busy), 32'd1);
      frame_pulse(1);
      chk("done_top_f4", 32'(drop_done), 32'd1);
      chk("busy_top_f4", 32'(drop_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/board_renderer_pipelined.md
Name: board_renderer_pipelined

Overview:
- Next-generation VGA pixel renderer for the connect-four display path; parametrised in board size, cell size, board origin and circle radius.
- Reads the board store through a synchronous read port and registers the colour path: 2-cycle latency, with syncs delayed to match.
- Adds two frame-timed effects: an animated falling-piece overlay with a busy/done handshake, and blinking of the winner's pieces.
- Sits between the VGA timing controller and the pins; the game core owns the board store.

Parameters:
- ROWS, 8, board rows (2..16)
- COLS, 8, board columns (2..16)
- CELL_LOG2, 5, log2 of cell size in pixels (cell = 32)
- BOARD_X, 192, left pixel of board
- BOARD_Y, 112, top line of board
- CURSOR_OFFSET, 16, gap in lines between cursor row and board top
- RADIUS, 14, piece radius in pixels (must be < 2^(CELL_LOG2-1))
- FALL_FRAMES, 4, frames per row step of the drop animation (>=1)
- BLINK_FRAMES, 16, frames per blink half-period (>=1)

Ports (RW = max(1,clog2(ROWS)), CW = max(1,clog2(COLS))):
- clk_25MHz  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- h_count  in  10  current pixel x from the timing controller
- v_count  in  10  current line y
- hsync_in  in  1  timing-controller hsync
- vsync_in  in  1  timing-controller vsync
- frame_start  in  1  one-cycle pulse once per frame
- board_rd_row  out  RW  board read row; 0 = bottom row
- board_rd_col  out  CW  board read column
- board_rd_data  in  2  cell contents one cycle after the address: 00 empty, 01 P1, 10 P2
- current_col  in  CW  cursor column
- current_player  in  2  01 P1, 10 P2
- winner  in  2  00 none, 01 P1, 10 P2, 11 draw
- drop_start  in  1  one-cycle request to start a drop animation
- drop_col  in  CW  drop column
- drop_row  in  RW  landing row (0 = bottom)
- drop_player  in  2  colour of the falling piece
- drop_busy  out  1  animation in progress
- drop_done  out  1  one-cycle pulse when the piece lands
- vga_hsync  out  1  hsync delayed 2 cycles
- vga_vsync  out  1  vsync delayed 2 cycles
- vga_r, vga_g, vga_b  out  2 each  registered colour

Behaviour:
- Reset values: all colour outputs 00, vga_hsync=1, vga_vsync=1, drop_busy=0, drop_done=0, FSM IDLE, frame counters 0, blink phase ON. Board read address outputs are combinational and have no reset value.
- Stage 0 (combinational from h_count/v_count):
  - offsets ox = h_count - BOARD_X, oy = v_count - BOARD_Y
  - col = ox >> CELL_LOG2, screen row sr = oy >> CELL_LOG2
  - board_rd_col = col, board_rd_row = ROWS-1-sr
  - in_board when the pixel lies inside the COLS x ROWS cell rectangle
  - cursor band: lines BOARD_Y-CURSOR_OFFSET-2^CELL_LOG2 up to (not including) BOARD_Y-CURSOR_OFFSET, same x range
- Circle test: dx = ox[CELL_LOG2-1:0] - 2^(CELL_LOG2-1), dy the same from oy, both signed. Pixel is in the circle when dx*dx + dy*dy <= RADIUS*RADIUS, evaluated at width 2*CELL_LOG2+1 with no wrap.
- Stage 1 register: in_board, in_cursor_band, in_circle, col, board row, active (h<640 and v<480), hsync_in, vsync_in. board_rd_data is valid in this cycle.
- Stage 2 register: colour and syncs. Colour priority:
  1. not active -> 000000.
  2. in_board and not in_circle -> board blue (00,00,11).
  3. in_board and in_circle, in order:
     - drop_busy and (col,row) equals (drop_col, anim_row) -> drop_player colour
     - else the piece is the winner's (winner 01/10) and blink phase is OFF -> empty colour
     - else board_rd_data 01 -> yellow (11,11,00); 10 -> red (11,00,00); 00/11 -> empty (01,11,01)
  4. in cursor band, col == current_col, in_circle, winner == 00 and not drop_busy -> current_player colour.
  5. otherwise -> empty colour.
- Drop FSM:
  - IDLE: drop_start with drop_row <= ROWS-1 and drop_col <= COLS-1 -> FALL; latch col/row/player, anim_row = ROWS-1, frame_cnt = 0. Out-of-range requests are ignored.
  - FALL: drop_busy = 1. On each frame_start, frame_cnt increments; when it reaches FALL_FRAMES-1 it clears and then:
    - anim_row > drop_row -> anim_row decrements
    - anim_row == drop_row -> drop_done pulses 1 cycle and the FSM returns to IDLE; drop_busy falls in the same cycle drop_done is high
  - drop_start while busy is ignored.
  - drop_row == ROWS-1 lands after exactly FALL_FRAMES frame_starts.
- Blink: while winner is 01 or 10, a counter advances on each frame_start and the phase toggles every BLINK_FRAMES frames. Winner 00 or 11 forces counter 0 and phase ON.
- Reset mid-frame or mid-animation: immediate return to the reset values; the next request starts cleanly.

Test Plan:
- Reset, then h=0..639 with v=0 (no board) -> colour 01,11,01 two cycles after each sample; h=640 -> 000000; syncs equal inputs delayed by 2.
- h=208, v=128 (centre of cell col 0, screen row 0 -> rd_row 7), board_rd_data=01 -> board_rd_row=7, board_rd_col=0; output 11,11,00 at +2 cycles. h=192, v=112 (cell corner) -> 00,00,11.
- current_col=3, current_player=10, winner=00, h=304, v=80 -> 11,00,00. Same pixel with winner=01 -> empty colour.
- FALL_FRAMES=4, ROWS=8: drop_start with col 2, row 5, player 01 -> drop_busy high; anim_row 7 -> 6 -> 5 at 4 frame_starts per step. drop_done pulses on the 12th frame_start; overlay drawn at (2, anim_row); a second drop_start during busy is ignored.
- winner=10, BLINK_FRAMES=16, P2 piece pixel -> red for frames 0-15, empty for 16-31, red again; winner back to 00 -> red immediately. Same test with winner=11 -> no blink.
- Assert rst during FALL -> drop_busy=0 and no drop_done pulse; vga_hsync/vga_vsync=1 and colour 000000 while rst is held.
